// File: rtl/ex_wb_pkg.sv
// Shared types for the execute-to-writeback stage: FSM state encoding and the buffered entry.
// Entries carry the widest supported fields; the stage zero-extends into them and slices back out.
package ex_wb_pkg;

    localparam int MAX_N    = 32;
    localparam int MAX_RA_W = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [MAX_N-1:0]    result;
        logic [1:0]          flags;
        logic [MAX_RA_W-1:0] rd;
        logic                we;
        logic                setf;
    } entry_t;

    function automatic logic [1:0] occupancy_of(input state_t s);
        logic [1:0] occ;
        occ = 2'd0;
        case (s)
            ONE:     occ = 2'd1;
            FULL:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/ex_wb_flag_reg.sv
// Committed ALU flag register; loads only when a compare-class entry commits.
module ex_wb_flag_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [1:0] d,
    output logic [1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 2'b00;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ex_wb_stage.sv
// Two-entry (head + skid) buffer between the ALU and the register file, with a committed flag register.
// Handshake: a transfer happens on an edge where valid && ready; in_ready is registered so out_ready never reaches it combinationally.
module ex_wb_stage
    import ex_wb_pkg::*;
#(
    parameter int N    = 4,
    parameter int RA_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    alu_result,
    input  logic [1:0]      alu_flags,
    input  logic [RA_W-1:0] in_rd,
    input  logic            in_we,
    input  logic            in_setf,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    wb_result,
    output logic [RA_W-1:0] wb_rd,
    output logic            wb_we,
    output logic [1:0]      flags_q,
    output logic [1:0]      occupancy,
    output state_t          fsm_state
);

    state_t state_q, state_n;
    entry_t head_q, head_n;
    entry_t skid_q, skid_n;
    entry_t in_entry;
    logic   in_ready_q;
    logic   accept;
    logic   commit;
    logic   unused_hi;

    always_comb begin
        in_entry        = '0;
        in_entry.result = MAX_N'(alu_result);
        in_entry.flags  = alu_flags;
        in_entry.rd     = MAX_RA_W'(in_rd);
        in_entry.we     = in_we;
        in_entry.setf   = in_setf;
    end

    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid && in_ready_q;
    assign commit    = out_valid && out_ready;

    always_comb begin
        state_n = state_q;
        head_n  = head_q;
        skid_n  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    head_n  = in_entry;
                    state_n = ONE;
                end
            end
            ONE: begin
                if (accept && commit) begin
                    head_n  = in_entry;
                end else if (accept) begin
                    skid_n  = in_entry;
                    state_n = FULL;
                end else if (commit) begin
                    state_n = EMPTY;
                end
            end
            FULL: begin
                if (commit) begin
                    head_n  = skid_q;
                    state_n = ONE;
                end
            end
            default: state_n = EMPTY;
        endcase
        // Flush empties the buffer but leaves the commit's flag update to the flag register.
        if (flush) begin
            state_n = EMPTY;
            head_n  = head_q;
            skid_n  = skid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_n;
            head_q     <= head_n;
            skid_q     <= skid_n;
            in_ready_q <= (state_n != FULL);
        end
    end

    ex_wb_flag_reg u_flag_reg (
        .clk  (clk),
        .rst  (rst),
        .load (commit && head_q.setf),
        .d    (head_q.flags),
        .q    (flags_q)
    );

    assign in_ready  = in_ready_q;
    assign wb_result = head_q.result[N-1:0];
    assign wb_rd     = head_q.rd[RA_W-1:0];
    assign wb_we     = head_q.we && out_valid;
    assign occupancy = occupancy_of(state_q);
    assign fsm_state = state_q;

    // Upper bits of the widened fields are always zero for this configuration.
    assign unused_hi = ^{head_q.result, head_q.rd, skid_q.result, skid_q.rd};

endmodule

// File: tb/tb_ex_wb_stage.sv
// Bench for ex_wb_stage: directed scenarios followed by random traffic, checked against a FIFO model.
module tb_ex_wb_stage;
    import ex_wb_pkg::*;

    localparam int ENT_W = 12;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] alu_result;
    logic [1:0] alu_flags;
    logic [3:0] in_rd;
    logic       in_we;
    logic       in_setf;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] wb_result;
    logic [3:0] wb_rd;
    logic       wb_we;
    logic [1:0] flags_q;
    logic [1:0] occupancy;
    state_t     fsm_state;

    int tests;
    int fails;

    // Model: entries packed as {result[11:8], flags[7:6], rd[5:2], we[1], setf[0]}.
    logic [ENT_W-1:0] exp_q[$];
    logic [1:0]       exp_flags;

    ex_wb_stage #(.N(4), .RA_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .in_rd      (in_rd),
        .in_we      (in_we),
        .in_setf    (in_setf),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .wb_result  (wb_result),
        .wb_rd      (wb_rd),
        .wb_we      (wb_we),
        .flags_q    (flags_q),
        .occupancy  (occupancy),
        .fsm_state  (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [ENT_W-1:0] f;
        chk("in_ready", in_ready, exp_q.size() < 2);
        chk("out_valid", out_valid, exp_q.size() > 0);
        chk("occupancy", occupancy, exp_q.size());
        chk("flags_q", flags_q, exp_flags);
        if (exp_q.size() > 0) begin
            f = exp_q[0];
            chk("wb_result", wb_result, f[11:8]);
            chk("wb_rd", wb_rd, f[5:2]);
            chk("wb_we", wb_we, f[1]);
        end else begin
            chk("wb_we_idle", wb_we, 1'b0);
        end
    endtask

    task automatic model_update(input logic iv, input logic [3:0] res, input logic [1:0] fl,
                                input logic [3:0] rd, input logic we, input logic setf,
                                input logic fsh, input logic ordy, input logic r);
        logic             do_commit;
        logic             do_accept;
        logic [ENT_W-1:0] f;
        do_commit = (exp_q.size() > 0) && ordy;
        do_accept = iv && (exp_q.size() < 2);
        if (r) begin
            exp_q.delete();
            exp_flags = 2'b00;
        end else begin
            if (do_commit) begin
                f = exp_q.pop_front();
                if (f[0]) exp_flags = f[7:6];
            end
            if (fsh) exp_q.delete();
            else if (do_accept) exp_q.push_back({res, fl, rd, we, setf});
        end
    endtask

    // Called at a falling edge: checks current outputs, drives inputs, advances one clock.
    task automatic step(input logic iv, input logic [3:0] res, input logic [1:0] fl,
                        input logic [3:0] rd, input logic we, input logic setf,
                        input logic fsh, input logic ordy, input logic r);
        check_all();
        in_valid   = iv;
        alu_result = res;
        alu_flags  = fl;
        in_rd      = rd;
        in_we      = we;
        in_setf    = setf;
        flush      = fsh;
        out_ready  = ordy;
        rst        = r;
        @(posedge clk);
        model_update(iv, res, fl, rd, we, setf, fsh, ordy, r);
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, ordy, 1'b0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        exp_flags = 2'b00;
        rst = 1'b1;
        in_valid = 1'b0;
        alu_result = '0;
        alu_flags = '0;
        in_rd = '0;
        in_we = 1'b0;
        in_setf = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;

        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_flags", flags_q, 2'b00);
        chk("rst_occ", occupancy, 2'd0);
        rst = 1'b0;

        // Back-to-back stream with out_ready high.
        step(1'b1, 4'd3, 2'b00, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("stream_first", wb_result, 4'd3);
        step(1'b1, 4'd7, 2'b00, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("stream_second", wb_result, 4'd7);
        step(1'b1, 4'd9, 2'b00, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("stream_third", wb_result, 4'd9);
        idle(1'b1);
        chk("stream_drained", occupancy, 2'd0);

        // Backpressure: fill both entries, then drain in order.
        step(1'b1, 4'd5, 2'b00, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd6, 2'b00, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_occ", occupancy, 2'd2);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_head", wb_result, 4'd5);
        step(1'b1, 4'd8, 2'b00, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_hold", wb_result, 4'd5);
        idle(1'b1);
        chk("bp_second", wb_result, 4'd6);
        idle(1'b1);
        chk("bp_empty", out_valid, 1'b0);

        // Flag commit: setf entry loads, non-setf entry leaves flags alone.
        step(1'b1, 4'd1, 2'b10, 4'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 4'd2, 2'b01, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("flag_load", flags_q, 2'b10);
        idle(1'b1);
        chk("flag_hold", flags_q, 2'b10);

        // Flush while full with a committing setf head.
        step(1'b1, 4'd4, 2'b11, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd5, 2'b00, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd12, 2'b01, 4'd11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("flush_occ", occupancy, 2'd0);
        chk("flush_flags", flags_q, 2'b11);
        chk("flush_in_ready", in_ready, 1'b1);

        // Reset while full, overriding a concurrent flush.
        step(1'b1, 4'd13, 2'b10, 4'd12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd14, 2'b01, 4'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd15, 2'b01, 4'd14, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst_full_flags", flags_q, 2'b00);
        chk("rst_full_valid", out_valid, 1'b0);
        chk("rst_full_ready", in_ready, 1'b1);
        chk("rst_full_result", wb_result, 4'd0);
        chk("rst_full_rd", wb_rd, 4'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 6,
                 4'($urandom), 2'($urandom), 4'($urandom),
                 1'($urandom), 1'($urandom),
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 9) < 6,
                 $urandom_range(0, 63) == 0);
        end
        idle(1'b1);
        check_all();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ex_wb_stage.md
EX_WB_STAGE -- requirements
Module: ex_wb_stage

Interface
REQ-001 Parameter N, default 4, data width of the ALU result carried through the stage.
REQ-002 Parameter RA_W, default 4, destination-register address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  ALU stage presents an operation.
REQ-006 in_ready  output  1  stage accepts; transfer when in_valid && in_ready.
REQ-007 alu_result  input  N  ALU result.
REQ-008 alu_flags  input  2  ALU flags.
REQ-009 in_rd  input  RA_W  destination register.
REQ-010 in_we  input  1  register write requested.
REQ-011 in_setf  input  1  operation updates the flag register (compare-class).
REQ-012 flush  input  1  discard all buffered operations.
REQ-013 out_valid  output  1  write-back entry available.
REQ-014 out_ready  input  1  register file consumes; commit when out_valid && out_ready.
REQ-015 wb_result, wb_rd, wb_we  output  N, RA_W, 1  head entry fields; wb_we = head.we && out_valid.
REQ-016 flags_q  output  2  committed flag register.
REQ-017 occupancy  output  2  entries held (0..2).

Function
REQ-018 Two-entry buffer (head, skid) of {result, flags, rd, we, setf}; FSM states EMPTY, ONE, FULL.
REQ-019 in_ready SHALL be a registered output, equal to 1 in EMPTY and ONE and 0 in FULL.
REQ-020 out_valid SHALL be 1 exactly in ONE and FULL; head drives wb_* outputs.
REQ-021 EMPTY: accept -> ONE (entry to head); else stay.
REQ-022 ONE: accept only -> FULL (entry to skid); commit only -> EMPTY; accept and commit together -> ONE (new entry to head).
REQ-023 FULL: commit -> ONE (skid moves to head); no accept possible.
REQ-024 Latency: entry accepted at edge k is visible on wb_* after edge k, i.e. one cycle; throughput one entry per cycle when out_ready held high.
REQ-025 Order SHALL be preserved; no entry duplicated or dropped except by flush/rst.
REQ-026 On commit with head.setf=1, flags_q <= head.flags at the same edge; otherwise flags_q holds.
REQ-027 flush=1 at an edge: state -> EMPTY, in_ready -> 1, simultaneous accept ignored, simultaneous commit SHALL still update flags_q if head.setf=1.
REQ-028 flush takes priority over all other transitions except rst.
REQ-029 wb_result/wb_rd SHALL hold stable while out_valid && !out_ready.
REQ-030 occupancy = 0/1/2 for EMPTY/ONE/FULL.

Reset
REQ-031 rst=1 at an edge: state EMPTY, in_ready=1, out_valid=0, flags_q=2'b00, occupancy=0, buffer data cleared to zero.
REQ-032 rst overrides flush, accept and commit in the same cycle; in-flight entries are discarded.

Structure
REQ-033 Shared package ex_wb_pkg SHALL hold the state enum (EMPTY, ONE, FULL) and the entry struct typedef.
REQ-034 Flag register SHALL be a sub-module ex_wb_flag_reg (clk, rst, load, d[1:0], q[1:0]).
REQ-035 No combinational path from out_ready to in_ready.

Verification
REQ-036 Reset: rst high 2 cycles -> in_ready=1, out_valid=0, flags_q=00, occupancy=0.
REQ-037 Stream: out_ready=1, send results 3,7,9 back-to-back -> wb_result 3,7,9 on consecutive cycles, each one cycle after acceptance.
REQ-038 Backpressure: out_ready=0, send 5 then 6 -> occupancy 2, in_ready=0, wb_result held at 5; raise out_ready -> 5 then 6 commit in order.
REQ-039 Flags: commit entry setf=1 flags=10 -> flags_q=10; next commit setf=0 flags=01 -> flags_q stays 10.
REQ-040 Flush while FULL with head setf=1 flags=11 and out_ready=1 -> state EMPTY, flags_q=11, concurrent input dropped.
REQ-041 rst asserted while FULL and flush=1 -> all outputs at reset values next cycle, flags_q=00.
